// File: rtl/pe_pkg.sv
// Shared types and constants for the PE stream driver and its result register.
package pe_pkg;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drv_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/pe_result_skid.sv
// Pops the PE output FIFO one word at a time and presents it on a valid/ready
// stream, tagging the final result of the job.
module pe_result_skid
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pop_en,
    input  logic              pop_last,
    input  logic              pe_out_empty,
    input  logic [DATA_W-1:0] pe_result,
    output logic              pe_read_out,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_last
);

    logic              read_r;
    logic              read_last_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              valid_r;
    logic              last_r;
    logic [DATA_W-1:0] data_r;
    logic              pop_s;

    // A pop is issued only when nothing is in flight, so the register is free when its data lands
    always_comb begin
        pop_s = pop_en && !pe_out_empty && !read_r && !inflight_r && (!valid_r || res_ready);
    end

    // Pop strobe, in-flight tracking and the output result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_r          <= 1'b0;
            read_last_r     <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            valid_r         <= 1'b0;
            last_r          <= 1'b0;
            data_r          <= {DATA_W{1'b0}};
        end else begin
            read_r          <= pop_s;
            read_last_r     <= pop_s && pop_last;
            inflight_r      <= read_r;
            inflight_last_r <= read_last_r;
            if (inflight_r) begin
                valid_r <= 1'b1;
                data_r  <= pe_result;
                last_r  <= inflight_last_r;
            end else if (valid_r && res_ready) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                valid_r <= valid_r;
                last_r  <= last_r;
            end
        end
    end

    assign pe_read_out = read_r;
    assign res_valid   = valid_r;
    assign res_data    = data_r;
    assign res_last    = last_r;

endmodule

// File: rtl/pe_stream_driver.sv
// Feeds operand pairs from two sync-read memories into the PE and drains its
// dot-product results. Optional perf counters are enabled by PE_DRIVER_PERF_EN.
module pe_stream_driver
    import pe_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int OUT_CREDITS = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [LEN_W-1:0]  cfg_num_vecs,
    input  logic [ADDR_W-1:0] cfg_base_a,
    input  logic [ADDR_W-1:0] cfg_base_b,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [DATA_W-1:0] mem_data_a,
    input  logic [DATA_W-1:0] mem_data_b,
    output logic [DATA_W-1:0] pe_length,
    output logic              pe_push,
    output logic [DATA_W-1:0] pe_left,
    output logic [DATA_W-1:0] pe_right,
    output logic              pe_read_out,
    input  logic              pe_out_empty,
    input  logic [DATA_W-1:0] pe_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
`ifdef PE_DRIVER_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    output logic              res_last
);

    localparam int CRED_W = $clog2(OUT_CREDITS + 1) + 1;

    drv_state_t        state_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  vecs_r;
    logic [LEN_W-1:0]  elem_cnt_r;
    logic [LEN_W-1:0]  vec_cnt_r;
    logic [LEN_W-1:0]  pop_cnt_r;
    logic [ADDR_W-1:0] ptr_a_r;
    logic [ADDR_W-1:0] ptr_b_r;
    logic [ADDR_W-1:0] addr_a_r;
    logic [ADDR_W-1:0] addr_b_r;
    logic [CRED_W-1:0] commit_cnt_r;
    logic [DATA_W-1:0] length_r;
    logic              busy_r;
    logic              done_r;
    logic              rd_en_r;
    logic              push_r;

    logic elem_last_s;
    logic credit_block_s;
    logic issue_s;
    logic job_last_s;
    logic commit_inc_s;
    logic pop_en_s;
    logic pop_last_s;
    logic cfg_zero_s;
    logic res_fire_s;
    logic read_out_s;
    logic res_valid_s;
    logic res_last_s;

    // Credits are taken when a vector's last read is issued, one step ahead of its
    // last push, so in-flight pushes can never overshoot the PE output FIFO.
    always_comb begin
        elem_last_s    = (elem_cnt_r == (len_r - 16'd1));
        credit_block_s = (elem_cnt_r == 16'd0) && (commit_cnt_r >= CRED_W'(OUT_CREDITS));
        issue_s        = (state_r == FETCH) && !credit_block_s;
        job_last_s     = issue_s && elem_last_s && (vec_cnt_r == (vecs_r - 16'd1));
        commit_inc_s   = issue_s && elem_last_s;
        pop_en_s       = ((state_r == FETCH) || (state_r == DRAIN)) && (pop_cnt_r != vecs_r);
        pop_last_s     = (pop_cnt_r == (vecs_r - 16'd1));
        cfg_zero_s     = (cfg_len == 16'd0) || (cfg_num_vecs == 16'd0);
        res_fire_s     = res_valid_s && res_ready && res_last_s;
    end

    // Job FSM, read addressing, element/vector/pop counters and credit tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_en_r      <= 1'b0;
            push_r       <= 1'b0;
            len_r        <= 16'd0;
            vecs_r       <= 16'd0;
            elem_cnt_r   <= 16'd0;
            vec_cnt_r    <= 16'd0;
            pop_cnt_r    <= 16'd0;
            ptr_a_r      <= {ADDR_W{1'b0}};
            ptr_b_r      <= {ADDR_W{1'b0}};
            addr_a_r     <= {ADDR_W{1'b0}};
            addr_b_r     <= {ADDR_W{1'b0}};
            commit_cnt_r <= {CRED_W{1'b0}};
            length_r     <= 32'd0;
        end else begin
            rd_en_r <= issue_s;
            push_r  <= rd_en_r;
            done_r  <= 1'b0;

            if (issue_s) begin
                addr_a_r   <= ptr_a_r;
                addr_b_r   <= ptr_b_r;
                ptr_a_r    <= ptr_a_r + ADDR_W'(1'b1);
                ptr_b_r    <= ptr_b_r + ADDR_W'(1'b1);
                elem_cnt_r <= elem_last_s ? 16'd0 : (elem_cnt_r + 16'd1);
                vec_cnt_r  <= elem_last_s ? (vec_cnt_r + 16'd1) : vec_cnt_r;
            end else begin
                elem_cnt_r <= elem_cnt_r;
            end

            if (read_out_s) begin
                pop_cnt_r <= pop_cnt_r + 16'd1;
            end else begin
                pop_cnt_r <= pop_cnt_r;
            end

            case ({commit_inc_s, read_out_s})
                2'b10:   commit_cnt_r <= commit_cnt_r + CRED_W'(1'b1);
                2'b01:   commit_cnt_r <= commit_cnt_r - CRED_W'(1'b1);
                default: commit_cnt_r <= commit_cnt_r;
            endcase

            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r        <= cfg_len;
                        vecs_r       <= cfg_num_vecs;
                        length_r     <= {16'd0, cfg_len};
                        ptr_a_r      <= cfg_base_a;
                        ptr_b_r      <= cfg_base_b;
                        elem_cnt_r   <= 16'd0;
                        vec_cnt_r    <= 16'd0;
                        pop_cnt_r    <= 16'd0;
                        commit_cnt_r <= {CRED_W{1'b0}};
                        busy_r       <= 1'b1;
                        if (cfg_zero_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    state_r <= job_last_s ? DRAIN : FETCH;
                end
                DRAIN: begin
                    if (res_fire_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    pe_result_skid u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop_en       (pop_en_s),
        .pop_last     (pop_last_s),
        .pe_out_empty (pe_out_empty),
        .pe_result    (pe_result),
        .pe_read_out  (read_out_s),
        .res_ready    (res_ready),
        .res_valid    (res_valid_s),
        .res_data     (res_data),
        .res_last     (res_last_s)
    );

`ifdef PE_DRIVER_PERF_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_stall_r;

    // Busy-cycle and credit-stall counters, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else if ((state_r == IDLE) && start) begin
            perf_cycles_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else begin
            perf_cycles_r <= busy_r ? sat_inc32(perf_cycles_r) : perf_cycles_r;
            perf_stall_r  <= ((state_r == FETCH) && credit_block_s) ? sat_inc32(perf_stall_r)
                                                                    : perf_stall_r;
        end
    end

    assign perf_cycles = perf_cycles_r;
    assign perf_stall  = perf_stall_r;
`endif

    // Operands come straight from the memory read port, aligned with the registered push
    assign pe_left     = mem_data_a;
    assign pe_right    = mem_data_b;
    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_rd_en   = rd_en_r;
    assign mem_addr_a  = addr_a_r;
    assign mem_addr_b  = addr_b_r;
    assign pe_length   = length_r;
    assign pe_push     = push_r;
    assign pe_read_out = read_out_s;
    assign res_valid   = res_valid_s;
    assign res_last    = res_last_s;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed bench: memory and PE models around pe_stream_driver, one task per scenario.
module tb_pe_stream_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_len = 16'd0;
    logic [15:0] cfg_num_vecs = 16'd0;
    logic [15:0] cfg_base_a = 16'd0;
    logic [15:0] cfg_base_b = 16'd0;
    logic        busy, done, mem_rd_en, pe_push, pe_read_out, res_valid, res_last;
    logic [15:0] mem_addr_a, mem_addr_b;
    logic [31:0] mem_data_a, mem_data_b, pe_length, pe_left, pe_right, res_data;
    logic        pe_out_empty = 1'b1;
    logic [31:0] pe_result = 32'd0;
    logic        res_ready = 1'b0;
`ifdef PE_DRIVER_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    logic [31:0] mem_a [0:65535];
    logic [31:0] mem_b [0:65535];

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int rd_cnt = 0;
    int push_cnt = 0;
    int done_cnt = 0;
    int last_cyc = 0;
    int done_cyc = 0;
    logic [15:0] addr_q [$];
    logic [31:0] left_q [$];
    int          push_cyc_q [$];
    logic [31:0] res_q [$];
    logic        last_q [$];

    logic [31:0] pe_q [$];
    logic [31:0] acc = 32'd0;
    logic [31:0] acc_cnt = 32'd0;

    pe_stream_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_num_vecs (cfg_num_vecs),
        .cfg_base_a   (cfg_base_a),
        .cfg_base_b   (cfg_base_b),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_addr_a   (mem_addr_a),
        .mem_addr_b   (mem_addr_b),
        .mem_data_a   (mem_data_a),
        .mem_data_b   (mem_data_b),
        .pe_length    (pe_length),
        .pe_push      (pe_push),
        .pe_left      (pe_left),
        .pe_right     (pe_right),
        .pe_read_out  (pe_read_out),
        .pe_out_empty (pe_out_empty),
        .pe_result    (pe_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
`ifdef PE_DRIVER_PERF_EN
        .perf_cycles  (perf_cycles),
        .perf_stall   (perf_stall),
`endif
        .res_last     (res_last)
    );

    always #5 clk = ~clk;

    // Sync-read operand memories
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data_a <= mem_a[mem_addr_a];
            mem_data_b <= mem_b[mem_addr_b];
        end
    end

    // PE model: accumulate pairs, queue one result per pe_length pushes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_q.delete();
            acc = 32'd0;
            acc_cnt = 32'd0;
            pe_out_empty <= 1'b1;
            pe_result <= 32'd0;
        end else begin
            if (pe_read_out && (pe_q.size() > 0)) pe_result <= pe_q.pop_front();
            if (pe_push) begin
                acc = acc + pe_left * pe_right;
                acc_cnt = acc_cnt + 32'd1;
                if (acc_cnt == pe_length) begin
                    pe_q.push_back(acc);
                    acc = 32'd0;
                    acc_cnt = 32'd0;
                end
            end
            pe_out_empty <= (pe_q.size() == 0);
        end
    end

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_rd_en) begin
            rd_cnt = rd_cnt + 1;
            addr_q.push_back(mem_addr_a);
        end
        if (pe_push) begin
            push_cnt = push_cnt + 1;
            left_q.push_back(pe_left);
            push_cyc_q.push_back(cyc);
        end
        if (res_valid && res_ready) begin
            res_q.push_back(res_data);
            last_q.push_back(res_last);
            if (res_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic start_job(input logic [15:0] len, input logic [15:0] vecs,
                             input logic [15:0] ba, input logic [15:0] bb);
        @(posedge clk); #1;
        cfg_len = len;
        cfg_num_vecs = vecs;
        cfg_base_a = ba;
        cfg_base_b = bb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, mem_rd_en, pe_push, pe_read_out, res_valid, res_last} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {busy, done, mem_rd_en, pe_push, pe_read_out, res_valid, res_last});
        end
        checks++;
        if (res_data !== 32'd0 || pe_length !== 32'd0 || mem_addr_a !== 16'd0 || mem_addr_b !== 16'd0) begin
            failures++;
            $display("FAIL reset_values: res_data=%0h pe_length=%0h addr_a=%0h addr_b=%0h expected all 0",
                     res_data, pe_length, mem_addr_a, mem_addr_b);
        end
    endtask

    task automatic test_single();
        int p0, r0, d0;
        p0 = push_cnt; r0 = res_q.size(); d0 = done_cnt;
        res_ready = 1'b1;
        start_job(16'd4, 16'd1, 16'h0010, 16'h0100);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pe_length !== 32'd4) begin
            failures++;
            $display("FAIL single_busy_len: busy=%b pe_length=%0d expected busy=1 pe_length=4", busy, pe_length);
        end
        wait_done(d0, 100);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL single_done: done pulses=%0d expected 1", done_cnt - d0);
        end
        checks++;
        if (push_cnt - p0 != 4) begin
            failures++;
            $display("FAIL single_push_count: got %0d expected 4", push_cnt - p0);
        end else begin
            checks++;
            if (push_cyc_q[p0+3] - push_cyc_q[p0] != 3) begin
                failures++;
                $display("FAIL single_push_consecutive: span %0d cycles expected 3",
                         push_cyc_q[p0+3] - push_cyc_q[p0]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (left_q[p0+k] !== 32'(k + 1)) begin
                    failures++;
                    $display("FAIL single_left[%0d]: got %0d expected %0d", k, left_q[p0+k], k + 1);
                end
            end
        end
        checks++;
        if (res_q.size() - r0 != 1) begin
            failures++;
            $display("FAIL single_res_count: got %0d expected 1", res_q.size() - r0);
        end else begin
            checks++;
            if (res_q[r0] !== 32'd10 || last_q[r0] !== 1'b1) begin
                failures++;
                $display("FAIL single_result: data=%0d last=%b expected data=10 last=1", res_q[r0], last_q[r0]);
            end
        end
    endtask

    task automatic test_multi();
        int r0, d0;
        logic [31:0] exp_v [5];
        exp_v[0] = 32'd12; exp_v[1] = 32'd30; exp_v[2] = 32'd48; exp_v[3] = 32'd66; exp_v[4] = 32'd84;
        r0 = res_q.size(); d0 = done_cnt;
        res_ready = 1'b1;
        start_job(16'd3, 16'd5, 16'h0200, 16'h0300);
        wait_done(d0, 300);
        checks++;
        if (res_q.size() - r0 != 5 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL multi_count: results=%0d done=%0d expected results=5 done=1",
                     res_q.size() - r0, done_cnt - d0);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (res_q[r0+k] !== exp_v[k] || last_q[r0+k] !== (k == 4)) begin
                    failures++;
                    $display("FAIL multi_result[%0d]: data=%0d last=%b expected data=%0d last=%b",
                             k, res_q[r0+k], last_q[r0+k], exp_v[k], (k == 4));
                end
            end
            checks++;
            if (done_cyc != last_cyc + 1) begin
                failures++;
                $display("FAIL multi_done_timing: done at %0d expected %0d", done_cyc, last_cyc + 1);
            end
        end
    endtask

    task automatic test_credit();
        int p0, r0, d0, nlast;
        p0 = push_cnt; r0 = res_q.size(); d0 = done_cnt;
        res_ready = 1'b0;
        start_job(16'd1, 16'd20, 16'h0400, 16'h0500);
        repeat (60) @(negedge clk);
        checks++;
        if (push_cnt - p0 != 9) begin
            failures++;
            $display("FAIL credit_stall_pushes: got %0d expected 9", push_cnt - p0);
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd3 || res_q.size() != r0) begin
            failures++;
            $display("FAIL credit_held_result: valid=%b data=%0d transfers=%0d expected valid=1 data=3 transfers=0",
                     res_valid, res_data, res_q.size() - r0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done(d0, 600);
        checks++;
        if (res_q.size() - r0 != 20 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL credit_count: results=%0d done=%0d expected results=20 done=1",
                     res_q.size() - r0, done_cnt - d0);
        end else begin
            nlast = 0;
            for (int k = 0; k < 20; k++) begin
                checks++;
                if (res_q[r0+k] !== 32'(3 * (k + 1))) begin
                    failures++;
                    $display("FAIL credit_result[%0d]: got %0d expected %0d", k, res_q[r0+k], 3 * (k + 1));
                end
                if (last_q[r0+k]) nlast++;
            end
            checks++;
            if (nlast != 1 || last_q[r0+19] !== 1'b1) begin
                failures++;
                $display("FAIL credit_last: last flags=%0d final=%b expected 1 and 1", nlast, last_q[r0+19]);
            end
        end
    endtask

    task automatic test_zero();
        int rd0, p0, d0;
        rd0 = rd_cnt; p0 = push_cnt; d0 = done_cnt;
        start_job(16'd0, 16'd7, 16'h0000, 16'h0000);
        wait_done(d0, 3);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_done: pulses=%0d expected 1", done_cnt - d0);
        end
        checks++;
        if (rd_cnt != rd0 || push_cnt != p0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_activity: reads=%0d pushes=%0d busy=%b expected 0 0 0",
                     rd_cnt - rd0, push_cnt - p0, busy);
        end
    endtask

    task automatic test_wrap();
        int a0, r0, d0;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        a0 = addr_q.size(); r0 = res_q.size(); d0 = done_cnt;
        res_ready = 1'b1;
        start_job(16'd4, 16'd1, 16'hFFFE, 16'h0600);
        wait_done(d0, 100);
        checks++;
        if (addr_q.size() - a0 != 4) begin
            failures++;
            $display("FAIL wrap_reads: got %0d expected 4", addr_q.size() - a0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (addr_q[a0+k] !== exp_a[k]) begin
                    failures++;
                    $display("FAIL wrap_addr[%0d]: got %h expected %h", k, addr_q[a0+k], exp_a[k]);
                end
            end
        end
        checks++;
        if (res_q.size() - r0 != 1 || res_q[res_q.size()-1] !== 32'd26) begin
            failures++;
            $display("FAIL wrap_result: transfers=%0d expected 1 with data 26", res_q.size() - r0);
        end
    endtask

    task automatic test_abort();
        int r0, d0;
        res_ready = 1'b1;
        start_job(16'd8, 16'd4, 16'h0700, 16'h0780);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL abort_midjob: busy=%b mem_rd_en=%b expected 1 1", busy, mem_rd_en);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, pe_push, pe_read_out, res_valid, res_last} !== 7'b0
            || pe_length !== 32'd0 || mem_addr_a !== 16'd0) begin
            failures++;
            $display("FAIL abort_async_reset: strobes=%b pe_length=%0d addr_a=%h expected all 0",
                     {busy, done, mem_rd_en, pe_push, pe_read_out, res_valid, res_last}, pe_length, mem_addr_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        r0 = res_q.size(); d0 = done_cnt;
        start_job(16'd2, 16'd1, 16'h0800, 16'h0900);
        wait_done(d0, 100);
        checks++;
        if (done_cnt - d0 != 1 || res_q.size() - r0 != 1) begin
            failures++;
            $display("FAIL abort_restart: done=%0d results=%0d expected 1 1", done_cnt - d0, res_q.size() - r0);
        end else begin
            checks++;
            if (res_q[r0] !== 32'd39 || last_q[r0] !== 1'b1) begin
                failures++;
                $display("FAIL abort_result: data=%0d last=%b expected 39 1", res_q[r0], last_q[r0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        for (int k = 0; k < 4; k++) begin
            mem_a[16'h0010 + k] = 32'(k + 1);
            mem_b[16'h0100 + k] = 32'd1;
        end
        for (int k = 0; k < 15; k++) begin
            mem_a[16'h0200 + k] = 32'(k + 1);
            mem_b[16'h0300 + k] = 32'd2;
        end
        for (int k = 0; k < 20; k++) begin
            mem_a[16'h0400 + k] = 32'(k + 1);
            mem_b[16'h0500 + k] = 32'd3;
        end
        for (int k = 0; k < 32; k++) begin
            mem_a[16'h0700 + k] = 32'(k + 1);
            mem_b[16'h0780 + k] = 32'd1;
        end
        mem_a[16'hFFFE] = 32'd5;
        mem_a[16'hFFFF] = 32'd6;
        mem_a[16'h0000] = 32'd7;
        mem_a[16'h0001] = 32'd8;
        for (int k = 0; k < 4; k++) mem_b[16'h0600 + k] = 32'd1;
        mem_a[16'h0800] = 32'd3; mem_a[16'h0801] = 32'd4;
        mem_b[16'h0900] = 32'd5; mem_b[16'h0901] = 32'd6;

        repeat (3) @(negedge clk);
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        test_single();
        test_multi();
        test_credit();
        test_zero();
        test_wrap();
        test_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
